// File: rtl/mem_stage_ext.sv
// Data-memory stage: byte/half/word loads and stores on an internal byte-lane RAM,
// with sign/zero extension, alignment checking and a stalling multi-cycle read.
module mem_stage_ext #(
  parameter int ADDR_W = 8,
  parameter int RD_LAT = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_valid,
  input  logic [31:0] i_alu,
  input  logic [31:0] i_data,
  input  logic        i_memWrite,
  input  logic        i_memRead,
  input  logic        i_memToReg,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic        o_stall,
  output logic        o_valid,
  output logic [31:0] o_data,
  output logic        o_misaligned
);

  localparam int         DEPTH      = 1 << ADDR_W;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_RD_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE    = 2'd2;
  localparam logic [2:0] CNT_INIT   = 3'(RD_LAT - 1);

  function automatic logic misal_f(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   misal_f = 1'b0;
      2'b01:   misal_f = a[0];
      default: misal_f = (a != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] byte_en_f(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   byte_en_f = 4'b0001 << a;
      2'b01:   byte_en_f = a[1] ? 4'b1100 : 4'b0011;
      default: byte_en_f = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_word_f(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   store_word_f = {4{d[7:0]}};
      2'b01:   store_word_f = {2{d[15:0]}};
      default: store_word_f = d;
    endcase
  endfunction

  function automatic logic [31:0] load_ext_f(input logic [31:0] w, input logic [1:0] size,
                                             input logic [1:0] a, input logic uns);
    logic [31:0] sh;
    logic [15:0] h;
    sh = w >> {a, 3'b000};
    h  = a[1] ? w[31:16] : w[15:0];
    case (size)
      2'b00:   load_ext_f = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   load_ext_f = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: load_ext_f = w;
    endcase
  endfunction

  logic [1:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [1:0]        addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              m2r_q, m2r_d;
  logic [31:0]       alu_q, alu_d;
  logic [31:0]       data_q, data_d;
  logic              mis_q, mis_d;
  logic [31:0]       rd_word_q;
  logic [31:0]       mem_q [DEPTH];

  logic              misal_s;
  logic              we_s;
  logic              rd_en_s;
  logic [3:0]        be_s;
  logic [31:0]       wdata_s;
  logic [ADDR_W-1:0] widx_s;

  assign widx_s  = i_alu[ADDR_W+1:2];
  assign misal_s = (i_memWrite | i_memRead) & misal_f(i_size, i_alu[1:0]);
  assign be_s    = byte_en_f(i_size, i_alu[1:0]);
  assign wdata_s = store_word_f(i_size, i_data);

  // Next-state and datapath decisions
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    m2r_d   = m2r_q;
    alu_d   = alu_q;
    data_d  = data_q;
    mis_d   = mis_q;
    we_s    = 1'b0;
    rd_en_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_valid) begin
          if (misal_s) begin
            data_d  = 32'h0000_0000;
            mis_d   = 1'b1;
            state_d = ST_DONE;
          end else if (i_memWrite) begin
            we_s    = 1'b1;
            data_d  = i_alu;
            mis_d   = 1'b0;
            state_d = ST_DONE;
          end else if (i_memRead) begin
            rd_en_s = 1'b1;
            cnt_d   = CNT_INIT;
            addr_d  = i_alu[1:0];
            size_d  = i_size;
            uns_d   = i_unsigned;
            m2r_d   = i_memToReg;
            alu_d   = i_alu;
            mis_d   = 1'b0;
            state_d = ST_RD_WAIT;
          end else begin
            data_d  = i_alu;
            mis_d   = 1'b0;
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_WAIT: begin
        // rd_word_q was captured at accept; no store can intervene while stalled
        if (cnt_q == 3'd0) begin
          data_d  = m2r_q ? load_ext_f(rd_word_q, size_q, addr_q, uns_q) : alu_q;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and result registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      addr_q  <= 2'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      m2r_q   <= 1'b0;
      alu_q   <= 32'h0000_0000;
      data_q  <= 32'h0000_0000;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      m2r_q   <= m2r_d;
      alu_q   <= alu_d;
      data_q  <= data_d;
      mis_q   <= mis_d;
    end
  end

  // Byte-lane RAM with synchronous read; contents survive reset
  always_ff @(posedge i_clk) begin
    for (int l = 0; l < 4; l++) begin
      if (we_s && be_s[l]) begin
        mem_q[widx_s][l*8 +: 8] <= wdata_s[l*8 +: 8];
      end
    end
    if (rd_en_s) begin
      rd_word_q <= mem_q[widx_s];
    end
  end

  assign o_stall      = (state_q != ST_IDLE);
  assign o_valid      = (state_q == ST_DONE);
  assign o_misaligned = (state_q == ST_DONE) & mis_q;
  assign o_data       = data_q;

endmodule

// File: tb/tb_mem_stage_ext.sv
// Scoreboard bench for mem_stage_ext: one instance per RD_LAT in 1..4, each driven by
// directed and random requests and checked against a byte-addressed memory model.
module tb_mem_stage_ext;

  localparam int ADDR_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int errors   = 0;
  int finished = 0;

  typedef struct {
    int          acc;
    int          due;
    logic [31:0] data;
    logic        mis;
  } exp_t;

  for (genvar g = 0; g < 4; g++) begin : g_lat
    localparam int LAT = g + 1;

    logic        rst_n, valid, we, re, m2r, uns;
    logic [1:0]  size;
    logic [31:0] alu, wd;
    logic        stall, ovalid, omis;
    logic [31:0] odata;

    logic [7:0]  mem_m [int];
    exp_t        q[$];

    mem_stage_ext #(.ADDR_W(ADDR_W), .RD_LAT(LAT)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_alu(alu), .i_data(wd),
      .i_memWrite(we), .i_memRead(re), .i_memToReg(m2r), .i_size(size),
      .i_unsigned(uns), .o_stall(stall), .o_valid(ovalid), .o_data(odata),
      .o_misaligned(omis)
    );

    function automatic int nbytes(input logic [1:0] sz);
      return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    // Little-endian load of nb bytes, then sign or zero extension
    function automatic logic [31:0] model_load(input logic [31:0] a, input int nb, input logic u);
      logic [31:0] v;
      v = 32'd0;
      for (int i = 0; i < nb; i++)
        v = v | (32'(mem_m[int'((a + 32'(i)) & 32'h3FF)]) << (8 * i));
      if (!u && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
      return v;
    endfunction

    task automatic issue(input logic w, input logic r, input logic t, input logic [1:0] sz,
                         input logic u, input logic [31:0] a, input logic [31:0] d);
      int   n;
      int   nb;
      exp_t e;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (stall && n < 50);
      if (stall) begin
        checks++;
        errors++;
        $display("FAIL lat%0d accept_timeout: o_stall=%b required 0", LAT, stall);
      end
      valid = 1'b1; we = w; re = r; m2r = t; size = sz; uns = u; alu = a; wd = d;
      nb = nbytes(sz);
      e.acc = cyc + 1;
      e.due = cyc + 1;
      e.mis = 1'b0;
      if ((w || r) && ((a % 32'(nb)) != 32'd0)) begin
        e.data = 32'd0;
        e.mis  = 1'b1;
      end else if (w) begin
        for (int i = 0; i < nb; i++) mem_m[int'((a + 32'(i)) & 32'h3FF)] = 8'(d >> (8 * i));
        e.data = a;
      end else if (r) begin
        e.due  = cyc + 1 + LAT;
        e.data = t ? model_load(a, nb, u) : a;
      end else begin
        e.data = a;
      end
      q.push_back(e);
    endtask

    task automatic idle(input int n);
      @(negedge clk);
      valid = 1'b0;
      repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_zero(input string tag);
      checks++;
      if ({stall, ovalid, omis, odata} !== 35'd0) begin
        errors++;
        $display("FAIL lat%0d %s: stall=%b valid=%b mis=%b data=%h required all 0",
                 LAT, tag, stall, ovalid, omis, odata);
      end
    endtask

    // Monitor: stall profile every cycle, results popped when o_valid shows
    always @(negedge clk) begin : mon
      exp_t e;
      logic exp_stall;
      if (rst_n) begin
        exp_stall = (q.size() > 0) && (cyc >= q[0].acc);
        checks++;
        if (stall !== exp_stall) begin
          errors++;
          $display("FAIL lat%0d stall @%0d: got %b expected %b", LAT, cyc, stall, exp_stall);
        end
        if (ovalid === 1'b1) begin
          checks++;
          if (q.size() == 0) begin
            errors++;
            $display("FAIL lat%0d unexpected_valid @%0d: data=%h", LAT, cyc, odata);
          end else begin
            e = q.pop_front();
            if (cyc != e.due || odata !== e.data || omis !== e.mis) begin
              errors++;
              $display("FAIL lat%0d result @%0d: data=%h mis=%b, expected data=%h mis=%b @%0d",
                       LAT, cyc, odata, omis, e.data, e.mis, e.due);
            end
          end
        end else begin
          if (omis !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL lat%0d stray_misaligned @%0d: got %b expected 0", LAT, cyc, omis);
          end
          if (q.size() > 0 && cyc >= q[0].due) begin
            checks++;
            errors++;
            e = q.pop_front();
            $display("FAIL lat%0d missing_valid @%0d: got 0 expected 1 (data %h)", LAT, cyc, e.data);
          end
        end
      end
    end

    initial begin : stim
      logic [31:0] a, d;
      int          kind;
      rst_n = 1'b0; valid = 1'b0; we = 1'b0; re = 1'b0; m2r = 1'b0; uns = 1'b0;
      size = 2'b00; alu = 32'd0; wd = 32'd0;
      repeat (3) @(negedge clk);
      check_reset_zero("reset_state");
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++) issue(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'(i * 4), $urandom);

      // Alternating stores and loads with i_valid held high
      for (int i = 0; i < 4; i++) begin
        a = 32'h20 + 32'(i * 4);
        issue(1'b1, 1'b0, 1'b1, 2'b10, 1'b0, a, $urandom);
        issue(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, a, 32'd0);
      end

      issue(1'b1, 1'b0, 1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
      issue(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'd0);
      issue(1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0000_0080);
      issue(1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 32'h13, 32'd0);
      issue(1'b0, 1'b1, 1'b1, 2'b00, 1'b1, 32'h13, 32'd0);
      issue(1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 32'h16, 32'h0000_8001);
      issue(1'b0, 1'b1, 1'b1, 2'b01, 1'b0, 32'h16, 32'd0);
      issue(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h14, 32'd0);
      issue(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h21, 32'd0);
      issue(1'b1, 1'b0, 1'b0, 2'b01, 1'b0, 32'h23, 32'h0000_FFFF);
      issue(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'd0);
      issue(1'b0, 1'b0, 1'b0, 2'b10, 1'b0, 32'h12345678, 32'd0);
      issue(1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 32'h18, 32'd0);
      issue(1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h1C, 32'hA5A5_5A5A);
      issue(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h1C, 32'd0);

      // Reset in the middle of a load: the load is dropped, RAM is kept
      issue(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'd0);
      @(negedge clk);
      q.delete();
      rst_n = 1'b0;
      valid = 1'b0;
      #1 check_reset_zero("in_reset");
      repeat (2) begin
        @(negedge clk);
        check_reset_zero("in_reset");
      end
      @(negedge clk);
      rst_n = 1'b1;
      issue(1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'd0);

      for (int i = 0; i < 40; i++) begin
        kind = int'($urandom_range(0, 3));
        a    = 32'($urandom_range(0, 63));
        d    = $urandom;
        case (kind)
          0:       issue(1'b1, 1'b0, 1'($urandom), 2'($urandom), 1'($urandom), a, d);
          1:       issue(1'b0, 1'b1, 1'($urandom), 2'($urandom), 1'($urandom), a, d);
          2:       issue(1'b0, 1'b0, 1'($urandom), 2'b00, 1'($urandom), $urandom, d);
          default: issue(1'b1, 1'b1, 1'($urandom), 2'($urandom), 1'($urandom), a, d);
        endcase
        if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
      end

      idle(LAT + 6);
      finished++;
    end
  end

  initial begin : top
    for (int i = 0; i < 20000; i++) begin
      if (finished == 4) break;
      @(posedge clk);
    end
    if (finished != 4) begin
      checks++;
      errors++;
      $display("FAIL run_timeout: %0d of 4 sequences finished", finished);
    end
    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
